// File: rtl/aes_pkg.sv
// Shared AES datapath types: 32-bit words and the four-word 128-bit state/key.
package aes_pkg;
    localparam int AES_WORD_W = 32;
    localparam int AES_NWORDS = 4;

    typedef logic [AES_WORD_W-1:0] aes_word;
    typedef aes_word [AES_NWORDS-1:0] key_128;
    typedef logic [7:0] ByteType;
endpackage

// File: rtl/aes_pipe_stage.sv
// One enable-gated 128-bit register with asynchronous active-low clear.
module aes_pipe_stage
    import aes_pkg::*;
(
    input  logic   clk,
    input  logic   nrst,
    input  logic   en,
    input  key_128 d,
    output key_128 q
);
    key_128 r_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_q <= '0;
        else if (en)
            r_q <= d;
    end

    assign q = r_q;
endmodule

// File: rtl/aes_pipeline.sv
// Fixed-latency, enable-gated pipeline for a 128-bit AES state/key value.
// Define AES_PIPE_VALID_EN to add a valid_i/valid_o sideband chain.
module aes_pipeline
    import aes_pkg::*;
#(
    parameter int STAGES = 1,
    parameter int NWORDS = 4
) (
    input  logic   clk,
    input  logic   nrst,
    input  logic   en,
    input  key_128 input_i,
    output key_128 output_o
`ifdef AES_PIPE_VALID_EN
    ,
    input  logic   valid_i,
    output logic   valid_o
`endif
);
    if (STAGES < 1) begin : g_bad_stages
        $error("aes_pipeline: STAGES must be >= 1");
    end
    if (NWORDS != AES_NWORDS) begin : g_bad_nwords
        $error("aes_pipeline: NWORDS must be 4");
    end

    // w_stage[0] is the input tap, w_stage[k] the output of register k-1.
    key_128 w_stage [STAGES+1];

    assign w_stage[0] = input_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        aes_pipe_stage u_stage (
            .clk  (clk),
            .nrst (nrst),
            .en   (en),
            .d    (w_stage[k]),
            .q    (w_stage[k+1])
        );
    end

    assign output_o = w_stage[STAGES];

`ifdef AES_PIPE_VALID_EN
    // Sideband only: follows the data registers but never gates their load.
    logic [STAGES-1:0] r_vld_pipe;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vld_pipe <= '0;
        end else if (en) begin
            r_vld_pipe[0] <= valid_i;
            for (int k = 1; k < STAGES; k++)
                r_vld_pipe[k] <= r_vld_pipe[k-1];
        end
    end

    assign valid_o = r_vld_pipe[STAGES-1];
`endif
endmodule

// File: tb/tb_aes_pipeline.sv
// Bench for aes_pipeline at STAGES = 1, 2, 3 against a history-of-loads model.
module tb_aes_pipeline;
    import aes_pkg::*;

    logic   clk = 1'b0;
    logic   nrst;
    logic   en;
    key_128 din;
    key_128 q1, q2, q3;
    logic   vin;
`ifdef AES_PIPE_VALID_EN
    logic   v1, v2, v3;
`endif

    // Model: every value accepted on an enabled edge since the last reset.
    key_128 hist [$];
    bit     vhist [$];
    int     n_pass  = 0;
    int     n_total = 0;

    always #5 clk = ~clk;

    aes_pipeline #(.STAGES(1)) u_dut1 (
        .clk(clk), .nrst(nrst), .en(en), .input_i(din), .output_o(q1)
`ifdef AES_PIPE_VALID_EN
        , .valid_i(vin), .valid_o(v1)
`endif
    );
    aes_pipeline #(.STAGES(2)) u_dut2 (
        .clk(clk), .nrst(nrst), .en(en), .input_i(din), .output_o(q2)
`ifdef AES_PIPE_VALID_EN
        , .valid_i(vin), .valid_o(v2)
`endif
    );
    aes_pipeline #(.STAGES(3)) u_dut3 (
        .clk(clk), .nrst(nrst), .en(en), .input_i(din), .output_o(q3)
`ifdef AES_PIPE_VALID_EN
        , .valid_i(vin), .valid_o(v3)
`endif
    );

    function automatic key_128 exp_q(int s);
        if (hist.size() >= s) return hist[hist.size()-s];
        return '0;
    endfunction

    function automatic bit exp_v(int s);
        if (vhist.size() >= s) return vhist[vhist.size()-s];
        return 1'b0;
    endfunction

    function automatic key_128 rand_key();
        key_128 k;
        for (int w = 0; w < 4; w++) k[w] = $urandom;
        return k;
    endfunction

    // Advance one rising edge, record the load if any, return 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (nrst && en) begin
            hist.push_back(din);
            vhist.push_back(vin);
        end
        #1;
    endtask

    // Assert reset between edges; caller releases it.
    task automatic assert_rst();
        nrst = 1'b0;
        hist.delete();
        vhist.delete();
        #1;
    endtask

    task automatic release_rst();
        #2;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        n_total++;
        if (q1 !== '0 || q2 !== '0 || q3 !== '0)
            $display("FAIL reset_state q1=%h q3=%h want 0", q1, q3);
        else n_pass++;
        release_rst();
        din = '1; en = 1'b1;
        repeat (4) tick();
        n_total++;
        if (q3 !== exp_q(3))
            $display("FAIL preload q3=%h want %h", q3, exp_q(3));
        else n_pass++;
        #2;
        assert_rst();
        n_total++;
        if (q1 !== '0 || q2 !== '0 || q3 !== '0)
            $display("FAIL async_clear q1=%h q2=%h q3=%h want 0", q1, q2, q3);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            en = i[0];
            tick();
            n_total++;
            if (q1 !== '0 || q3 !== '0)
                $display("FAIL reset_hold%0d q1=%h q3=%h want 0", i, q1, q3);
            else n_pass++;
        end
        release_rst();
    endtask

    task automatic test_single_pass();
        en = 1'b1; din = 128'h4;
        n_total++;
        if (q1 !== '0)
            $display("FAIL single_before q1=%h want 0", q1);
        else n_pass++;
        tick();
        n_total++;
        if (q1 !== exp_q(1) || q1 !== 128'h4)
            $display("FAIL single_after q1=%h want %h", q1, exp_q(1));
        else n_pass++;
    endtask

    task automatic test_hold();
        key_128 pat;
        pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        din = pat; en = 1'b1;
        tick();
        en = 1'b0; din = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (q1 !== exp_q(1) || q1 !== pat || q2 !== exp_q(2) || q3 !== exp_q(3))
                $display("FAIL hold%0d q1=%h want %h q3=%h want %h", i, q1, exp_q(1), q3, exp_q(3));
            else n_pass++;
        end
        en = 1'b1;
        tick();
        n_total++;
        if (q1 !== exp_q(1) || q1 !== '0)
            $display("FAIL hold_resume q1=%h want %h", q1, exp_q(1));
        else n_pass++;
    endtask

    task automatic test_stream();
        #2;
        assert_rst();
        release_rst();
        en = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            din = (e <= 3) ? key_128'(e) : '0;
            tick();
            n_total++;
            if (q3 !== exp_q(3) || q3 !== ((e >= 3) ? key_128'(e-2) : key_128'(0)))
                $display("FAIL stream_edge%0d q3=%h want %h", e, q3, exp_q(3));
            else n_pass++;
        end
    endtask

    task automatic test_words();
        key_128 w_in;
        w_in = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        en = 1'b1; din = w_in;
        tick();
        din = '0;
        tick();
        tick();
        for (int w = 0; w < 4; w++) begin
            n_total++;
            if (q3[w] !== w_in[w])
                $display("FAIL word%0d q3=%h want %h", w, q3[w], w_in[w]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            din = rand_key();
            en  = ($urandom_range(0, 9) < 7);
            vin = $urandom_range(0, 1);
            tick();
            n_total++;
            if (q1 !== exp_q(1) || q2 !== exp_q(2) || q3 !== exp_q(3))
                $display("FAIL rand%0d q1=%h/%h q2=%h/%h q3=%h/%h", i,
                         q1, exp_q(1), q2, exp_q(2), q3, exp_q(3));
            else n_pass++;
`ifdef AES_PIPE_VALID_EN
            n_total++;
            if (v1 !== exp_v(1) || v2 !== exp_v(2) || v3 !== exp_v(3))
                $display("FAIL rand_valid%0d v=%b%b%b want %b%b%b", i,
                         v1, v2, v3, exp_v(1), exp_v(2), exp_v(3));
            else n_pass++;
`endif
            if ($urandom_range(0, 39) == 0) begin
                assert_rst();
                n_total++;
                if (q1 !== '0 || q2 !== '0 || q3 !== '0)
                    $display("FAIL rand_rst%0d q1=%h q2=%h q3=%h want 0", i, q1, q2, q3);
                else n_pass++;
                release_rst();
            end
        end
    endtask

`ifdef AES_PIPE_VALID_EN
    task automatic test_valid();
        int hi_cnt;
        #2;
        assert_rst();
        release_rst();
        hi_cnt = 0;
        en = 1'b1; vin = 1'b1; din = 128'hA5;
        tick();
        vin = 1'b0; din = '0;
        for (int e = 2; e <= 5; e++) begin
            tick();
            if (v2) hi_cnt++;
            n_total++;
            if (v2 !== exp_v(2) || v2 !== (e == 2) || (v2 && q2 !== 128'hA5))
                $display("FAIL valid_edge%0d v2=%b q2=%h want %b", e, v2, q2, exp_v(2));
            else n_pass++;
        end
        n_total++;
        if (hi_cnt != 1)
            $display("FAIL valid_pulse_len got %0d want 1", hi_cnt);
        else n_pass++;
        vin = 1'b1;
        tick();
        tick();
        #2;
        assert_rst();
        n_total++;
        if (v2 !== 1'b0 || v3 !== 1'b0)
            $display("FAIL valid_rst v2=%b v3=%b want 0", v2, v3);
        else n_pass++;
        vin = 1'b0;
        release_rst();
    endtask
`endif

    initial begin
        nrst = 1'b0; en = 1'b0; din = '0; vin = 1'b0;
        #1;
        test_reset();
        test_single_pass();
        test_hold();
        test_stream();
        test_words();
`ifdef AES_PIPE_VALID_EN
        test_valid();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
